// File: rtl/pipe_pkg.sv
// Shared state encodings for the elastic pipeline stage.
package pipe_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_EMPTY = 2'b00;
    localparam state_t ST_BUSY  = 2'b01;
    localparam state_t ST_FULL  = 2'b10;

endpackage

// File: rtl/pipe_stage_reg_en_reg.sv
// N-bit register with asynchronous active-low clear and load enable.
module en_reg #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a 2-entry skid buffer, valid/ready handshake and flush.
// Optional stall counter on stall_cnt when PIPE_STAGE_STATS_EN is defined.
//
// state    | meaning
// ---------+---------------------------------------
// EMPTY    | nothing held, out_valid=0
// BUSY     | main entry valid, skid empty
// FULL     | main and skid valid, input blocked
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int N = 32
`ifdef PIPE_STAGE_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    input  logic             out_ready
`ifdef PIPE_STAGE_STATS_EN
    , output logic [CNT_W-1:0] stall_cnt
`endif
);

    state_t       state_q;
    state_t       state_d;
    logic         accept_in;
    logic         accept_out;
    logic         main_en;
    logic         skid_en;
    logic         main_from_skid;
    logic [N-1:0] main_d;
    logic [N-1:0] main_q;
    logic [N-1:0] skid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept_in) begin
                    main_en = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept_in && accept_out) begin
                    main_en = 1'b1;
                end else if (accept_in) begin
                    skid_en = 1'b1;
                    state_d = ST_FULL;
                end else if (accept_out) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_out) begin
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush only clears validity; data registers keep their contents.
        if (flush) begin
            state_d        = ST_EMPTY;
            main_en        = 1'b0;
            skid_en        = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_EMPTY) || (state_q == ST_BUSY);
        out_valid = (state_q != ST_EMPTY);
    end

    assign accept_in  = in_valid & in_ready;
    assign accept_out = out_valid & out_ready;
    assign main_d     = main_from_skid ? skid_q : in_data;

    en_reg #(.N(N)) u_main_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    en_reg #(.N(N)) u_skid_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (skid_en),
        .d_i   (in_data),
        .q_o   (skid_q)
    );

    assign out_data = main_q;

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // Saturating; flush deliberately does not clear it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle plus directed literal checks.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
`ifdef PIPE_STAGE_STATS_EN
    logic [3:0]  stall_cnt;
    localparam int STALL_MAX = 15;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pipe_stage_reg #(
        .N(32)
`ifdef PIPE_STAGE_STATS_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the stage is a FIFO of at most two words; the head is what the main register shows.
    logic [31:0] mq[$];
    logic [31:0] m_main  = '0;
    int          m_stall = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit do_pop;
        bit do_push;
        if (!rst_n) begin
            mq.delete();
            m_main  = '0;
            m_stall = 0;
        end else begin
`ifdef PIPE_STAGE_STATS_EN
            if (mq.size() > 0 && !out_ready && m_stall < STALL_MAX) m_stall++;
`endif
            if (flush) begin
                mq.delete();
            end else begin
                do_pop  = (mq.size() > 0) && out_ready;
                do_push = in_valid && (mq.size() < 2);
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back(in_data);
                if (mq.size() > 0) m_main = mq[0];
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
        chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
        chk("cyc_out_data", out_data, m_main);
`ifdef PIPE_STAGE_STATS_EN
        chk("cyc_stall_cnt", {28'd0, stall_cnt}, m_stall);
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        repeat (3) cyc();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef PIPE_STAGE_STATS_EN
        chk("rst_stall", {28'd0, stall_cnt}, 32'd0);
`endif
        in_valid = 1'b0;
        rst_n    = 1'b1;
        cyc();

        // streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            cyc();
            chk("stream_data", out_data, i);
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("stream_drain_data", out_data, 32'd5);

        // backpressure into FULL, then drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        cyc();
        in_data = 32'hB;
        cyc();
        chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_full_data", out_data, 32'hA);
        in_valid = 1'b0;
        repeat (2) cyc();
        chk("bp_hold_data", out_data, 32'hA);
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
`ifdef PIPE_STAGE_STATS_EN
        chk("bp_stall", {28'd0, stall_cnt}, 32'd3);
`endif
        out_ready = 1'b1;
        cyc();
        chk("bp_second_data", out_data, 32'hB);
        chk("bp_second_in_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        chk("bp_empty_valid", {31'd0, out_valid}, 32'd0);

        // flush while FULL with a word presented
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hD;
        cyc();
        in_data = 32'hE;
        cyc();
        flush   = 1'b1;
        in_data = 32'hC;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_data_kept", out_data, 32'hD);
`ifdef PIPE_STAGE_STATS_EN
        chk("flush_stall", {28'd0, stall_cnt}, 32'd5);
`endif
        repeat (2) cyc();
        chk("flush_stays_empty", {31'd0, out_valid}, 32'd0);

        // flush together with a consuming downstream
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        cyc();
        in_valid = 1'b0;
        flush    = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_acc_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_acc_data", out_data, 32'h55);

        // asynchronous reset pulse mid-FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        cyc();
        in_data = 32'h22;
        cyc();
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_data", out_data, 32'd0);
        #2;
        rst_n = 1'b1;
        cyc();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h33;
        cyc();
        chk("arst_after_valid", {31'd0, out_valid}, 32'd1);
        chk("arst_after_data", out_data, 32'h33);
        in_valid = 1'b0;
        cyc();

        // long stall (saturates the counter in the stats build)
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h44;
        cyc();
        in_valid = 1'b0;
        repeat (20) cyc();
        chk("sat_hold_data", out_data, 32'h44);
`ifdef PIPE_STAGE_STATS_EN
        chk("sat_stall", {28'd0, stall_cnt}, 32'hF);
`endif
        out_ready = 1'b1;
        repeat (2) cyc();
        chk("sat_drain_valid", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
